// File: rtl/rotation_arb_pkg.sv
// Shared types and helpers for the rotation arbiter: output-stage state,
// requester count and left-to-right rotation amount conversion.
package rotation_arb_pkg;

    localparam int NUM_REQ         = 2;
    localparam int MAX_SHIFT_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Callers keep the low SHIFT_WIDTH bits; 2**MAX_SHIFT_WIDTH is a multiple of
    // every supported rotation range, so the negation stays correct modulo 2**SHIFT_WIDTH.
    function automatic logic [MAX_SHIFT_WIDTH-1:0] to_right_amt(
        input logic [MAX_SHIFT_WIDTH-1:0] amt,
        input logic                       dir
    );
        return dir ? (MAX_SHIFT_WIDTH'(0) - amt) : amt;
    endfunction

endpackage

// File: rtl/rotation_arbiter_if.sv
// Request and response handshake bundle between two requesters, the arbiter and
// the downstream consumer. master = requesters/consumer side, slave = arbiter.
interface rotation_arbiter_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 3
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [DATA_WIDTH-1:0]  req_data0;
    logic [SHIFT_WIDTH-1:0] req_amt0;
    logic                   req_dir0;
    logic [DATA_WIDTH-1:0]  req_data1;
    logic [SHIFT_WIDTH-1:0] req_amt1;
    logic                   req_dir1;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_id;

    modport master (
        output req_valid, req_data0, req_amt0, req_dir0,
               req_data1, req_amt1, req_dir1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data0, req_amt0, req_dir0,
               req_data1, req_amt1, req_dir1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/right_rotation.sv
// Combinational right rotate of in_data by shift_amt bit positions.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, output follows inputs.
module right_rotation #(
    parameter int INPUT_WIDTH = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic [INPUT_WIDTH-1:0] out_data
);

    logic [SHIFT_WIDTH-1:0] src_idx;

    // Index arithmetic wraps at SHIFT_WIDTH bits, which is the rotation itself
    // because INPUT_WIDTH == 2**SHIFT_WIDTH.
    always_comb begin
        out_data = '0;
        src_idx  = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            src_idx     = SHIFT_WIDTH'(i) + shift_amt;
            out_data[i] = in_data[src_idx];
        end
    end

endmodule

// File: rtl/rotation_arbiter.sv
// Round-robin shares one right-rotation datapath between two requesters.
// Latency: 1 cycle from accepted request to rsp_valid; one result per cycle.
// Backpressure: one-entry output stage; req_ready drops while full and rsp_ready low.
module rotation_arbiter
    import rotation_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rotation_arbiter_if.slave    bus,
    output logic [CNT_WIDTH-1:0] grant_cnt0,
    output logic [CNT_WIDTH-1:0] grant_cnt1
);

    out_state_e              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_id_q, rsp_id_d;
    logic [CNT_WIDTH-1:0]    cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]    cnt1_q, cnt1_d;

    logic                       can_accept;
    logic                       winner;
    logic                       xfer;
    logic [DATA_WIDTH-1:0]      win_data;
    logic [SHIFT_WIDTH-1:0]     win_amt;
    logic                       win_dir;
    logic [MAX_SHIFT_WIDTH-1:0] right_amt_full;
    logic [SHIFT_WIDTH-1:0]     eff_amt;
    logic [DATA_WIDTH-1:0]      rot_data;

    always_comb begin
        can_accept = (state_q == EMPTY) || bus.rsp_ready;
        // Contention goes to whoever did not win last; a lone requester always wins.
        case (bus.req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
        xfer          = (|bus.req_valid) && can_accept;
        bus.req_ready = xfer ? (winner ? 2'b10 : 2'b01) : 2'b00;

        win_data       = winner ? bus.req_data1 : bus.req_data0;
        win_amt        = winner ? bus.req_amt1  : bus.req_amt0;
        win_dir        = winner ? bus.req_dir1  : bus.req_dir0;
        right_amt_full = to_right_amt(MAX_SHIFT_WIDTH'(win_amt), win_dir);
        eff_amt        = right_amt_full[SHIFT_WIDTH-1:0];
    end

    right_rotation #(
        .INPUT_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_right_rotation (
        .in_data   (win_data),
        .shift_amt (eff_amt),
        .out_data  (rot_data)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (xfer) begin
            state_d      = FULL;
            last_grant_d = winner;
            rsp_data_d   = rot_data;
            rsp_id_d     = winner;
            if (!winner && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
            if ( winner && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
        end else if (bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign grant_cnt0    = cnt0_q;
    assign grant_cnt1    = cnt1_q;

endmodule

// File: tb/tb_rotation_arbiter.sv
// Bench for rotation_arbiter: a 16-bit-counter instance and a 2-bit-counter instance
// see identical stimulus and are compared against one transaction-level model.
module tb_rotation_arbiter;

    localparam int DW = 8;
    localparam int SW = 3;

    logic clk;
    logic reset_n;

    rotation_arbiter_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) ifa ();
    rotation_arbiter_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) ifb ();

    logic [15:0] gc0_a, gc1_a;
    logic [1:0]  gc0_b, gc1_b;

    assign ifb.req_valid = ifa.req_valid;
    assign ifb.req_data0 = ifa.req_data0;
    assign ifb.req_amt0  = ifa.req_amt0;
    assign ifb.req_dir0  = ifa.req_dir0;
    assign ifb.req_data1 = ifa.req_data1;
    assign ifb.req_amt1  = ifa.req_amt1;
    assign ifb.req_dir1  = ifa.req_dir1;
    assign ifb.rsp_ready = ifa.rsp_ready;

    rotation_arbiter #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .CNT_WIDTH(16)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (ifa),
        .grant_cnt0 (gc0_a),
        .grant_cnt1 (gc1_a)
    );

    rotation_arbiter #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .CNT_WIDTH(2)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (ifb),
        .grant_cnt0 (gc0_b),
        .grant_cnt1 (gc1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference state: one pending result, who won last, accepted transfers per requester.
    bit          m_full;
    logic [7:0]  m_data;
    int          m_id;
    int          m_last;
    int          m_cnt [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_rot(input logic [7:0] x, input int amt, input bit left);
        logic [7:0] y;
        y = x;
        for (int k = 0; k < amt; k++)
            y = left ? {y[6:0], y[7]} : {y[0], y[7:1]};
        return y;
    endfunction

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic model_reset();
        m_full   = 1'b0;
        m_data   = '0;
        m_id     = 0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic set_req(input logic [1:0] v,
                           input logic [7:0] d0, input int a0, input bit r0,
                           input logic [7:0] d1, input int a1, input bit r1,
                           input bit rr);
        ifa.req_valid = v;
        ifa.req_data0 = d0;
        ifa.req_amt0  = SW'(a0);
        ifa.req_dir0  = r0;
        ifa.req_data1 = d1;
        ifa.req_amt1  = SW'(a1);
        ifa.req_dir1  = r1;
        ifa.rsp_ready = rr;
    endtask

    task automatic rand_req(input int p_ready);
        set_req(2'($urandom_range(0, 3)),
                8'($urandom), $urandom_range(0, 7), 1'($urandom),
                8'($urandom), $urandom_range(0, 7), 1'($urandom),
                ($urandom_range(0, 99) < p_ready));
    endtask

    task automatic check_outputs();
        check_val("rsp_valid", ifa.rsp_valid, m_full);
        check_val("rsp_valid_c2", ifb.rsp_valid, m_full);
        if (m_full) begin
            check_val("rsp_data", ifa.rsp_data, m_data);
            check_val("rsp_id", ifa.rsp_id, m_id);
            check_val("rsp_data_c2", ifb.rsp_data, m_data);
            check_val("rsp_id_c2", ifb.rsp_id, m_id);
        end
        check_val("grant_cnt0", gc0_a, sat(m_cnt[0], 65535));
        check_val("grant_cnt1", gc1_a, sat(m_cnt[1], 65535));
        check_val("grant_cnt0_c2", gc0_b, sat(m_cnt[0], 3));
        check_val("grant_cnt1_c2", gc1_b, sat(m_cnt[1], 3));
    endtask

    // One clock: check handshake from model, clock, advance model, check outputs.
    task automatic step();
        bit         can;
        int         w;
        logic [1:0] exp_rdy;
        logic [7:0] res;
        can = !m_full || ifa.rsp_ready;
        if (ifa.req_valid == 2'b11) w = 1 - m_last;
        else                        w = ifa.req_valid[1] ? 1 : 0;
        exp_rdy = ((ifa.req_valid != 2'b00) && can) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        res = (w == 1) ? ref_rot(ifa.req_data1, int'(ifa.req_amt1), ifa.req_dir1)
                       : ref_rot(ifa.req_data0, int'(ifa.req_amt0), ifa.req_dir0);
        #1;
        check_val("req_ready", ifa.req_ready, exp_rdy);
        check_val("req_ready_c2", ifb.req_ready, exp_rdy);
        @(posedge clk);
        if (exp_rdy != 2'b00) begin
            m_full = 1'b1;
            m_data = res;
            m_id   = w;
            m_last = w;
            m_cnt[w]++;
        end else if (ifa.rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("rst_rsp_valid", ifa.rsp_valid, 1'b0);
        check_val("rst_rsp_data", ifa.rsp_data, 8'h00);
        check_val("rst_rsp_id", ifa.rsp_id, 1'b0);
        check_val("rst_cnt0", gc0_a, 16'd0);
        check_val("rst_cnt1", gc1_a, 16'd0);
        check_val("rst_cnt0_c2", gc0_b, 2'd0);
        check_val("rst_rsp_valid_c2", ifb.rsp_valid, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] held;
        int         sat_tbl [5];
        sat_tbl = '{1, 2, 3, 3, 3};
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        set_req(2'b00, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_val("init_rsp_data", ifa.rsp_data, 8'h00);
        check_val("init_rsp_id", ifa.rsp_id, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed rotations from the examples.
        set_req(2'b01, 8'hB4, 3, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        step();
        check_val("ex_right3", ifa.rsp_data, 8'h96);
        check_val("ex_right3_id", ifa.rsp_id, 1'b0);
        check_val("ex_right3_cnt", gc0_a, 16'd1);
        set_req(2'b10, 8'h00, 0, 1'b0, 8'hB4, 3, 1'b1, 1'b1);
        step();
        check_val("ex_left3", ifa.rsp_data, 8'hA5);
        check_val("ex_left3_id", ifa.rsp_id, 1'b1);
        set_req(2'b10, 8'h00, 0, 1'b0, 8'h3C, 0, 1'b1, 1'b1);
        step();
        check_val("ex_left0", ifa.rsp_data, 8'h3C);
        set_req(2'b00, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        step();

        // Counter saturation on the 2-bit instance.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(2'b01, 8'($urandom), $urandom_range(0, 7), 1'($urandom),
                    8'h00, 0, 1'b0, 1'b1);
            step();
            check_val("sat_seq", gc0_b, sat_tbl[i]);
        end

        // Continuous contention: strict alternation starting at requester 0.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            set_req(2'b11, 8'($urandom), $urandom_range(0, 7), 1'($urandom),
                    8'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b1);
            step();
            check_val("alt_id", ifa.rsp_id, i % 2);
        end
        check_val("alt_cnt0", gc0_a, 16'd5);
        check_val("alt_cnt1", gc1_a, 16'd5);

        // Stall with both requesting, then drain-and-refill in one cycle.
        held = ifa.rsp_data;
        for (int i = 0; i < 4; i++) begin
            set_req(2'b11, 8'($urandom), $urandom_range(0, 7), 1'($urandom),
                    8'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b0);
            step();
            check_val("stall_hold", ifa.rsp_data, held);
        end
        ifa.rsp_ready = 1'b1;
        step();
        check_val("refill_valid", ifa.rsp_valid, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_req(70);
            step();
        end

        // Asynchronous reset while holding a result.
        set_req(2'b10, 8'h5A, 1, 1'b0, 8'h5A, 1, 1'b0, 1'b0);
        step();
        check_val("pre_rst_full", ifa.rsp_valid, 1'b1);
        pulse_reset();
        set_req(2'b11, 8'h81, 1, 1'b0, 8'h42, 2, 1'b1, 1'b1);
        step();
        check_val("post_rst_id", ifa.rsp_id, 1'b0);
        check_val("post_rst_data", ifa.rsp_data, 8'hC0);

        for (int i = 0; i < 100; i++) begin
            rand_req(50);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rotation_arbiter.md
Name: rotation_arbiter

Overview:
Shares one combinational right-rotation datapath between two requesters. Each requester presents a word, a rotation amount and a direction over a valid/ready handshake. The block arbitrates round-robin, converts left rotations to equivalent right rotations, and registers the result into a one-entry output stage with its own valid/ready handshake. It sits between the requesting units and any downstream consumer of rotated words.

Parameters:
DATA_WIDTH, 8, word width; must equal 2**SHIFT_WIDTH
SHIFT_WIDTH, 3, rotation amount width
CNT_WIDTH, 16, width of the per-requester grant counters

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept, at most one bit high
req_data0  in  DATA_WIDTH  requester 0 word
req_amt0  in  SHIFT_WIDTH  requester 0 rotation amount
req_dir0  in  1  requester 0 direction, 0 = right, 1 = left
req_data1  in  DATA_WIDTH  requester 1 word
req_amt1  in  SHIFT_WIDTH  requester 1 rotation amount
req_dir1  in  1  requester 1 direction
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_data  out  DATA_WIDTH  rotated word
rsp_id  out  1  index of the requester that produced rsp_data
grant_cnt0  out  CNT_WIDTH  saturating count of accepted requester-0 transfers
grant_cnt1  out  CNT_WIDTH  saturating count of accepted requester-1 transfers

Behaviour:
- Reset (async, reset_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, grant_cnt0/1=0, last_grant=1 so requester 0 wins first.
- Output stage state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1. The same-cycle drain-and-refill case gives throughput 1 per cycle.
- Arbitration (combinational):
  - If only one req_valid bit is set, that requester wins.
  - If both are set, the requester other than last_grant wins.
  - req_ready[w] = can_accept for the winner w; the loser's ready is 0.
  - req_ready never depends on the loser's state.
- Transfer: req_valid[w] & req_ready[w].
  - On the next edge: rsp_data = rotated word, rsp_id = w, rsp_valid = 1, last_grant = w, grant_cnt<w> incremented.
  - grant_cnt<w> saturates at all-ones and never wraps.
- Latency: exactly 1 cycle from accepted request to rsp_valid.
- Transitions:
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY when rsp_ready=1 and no transfer.
  - FULL -> FULL when rsp_ready=1 and transfer (new data loaded), or when rsp_ready=0 (hold).
- While FULL with rsp_ready=0: rsp_data and rsp_id are held stable and both req_ready bits are 0.
- Amount conversion: eff_amt = dir ? (0 - amt) mod 2**SHIFT_WIDTH : amt.
  - Left by 0 gives eff 0.
  - Left by k gives right by DATA_WIDTH-k.
- Rotation: a pure right rotate of the winner's word by eff_amt. The amount 0 passes the word unchanged.
- Requesters may deassert req_valid without a transfer. No request is stored before acceptance.
- Reset mid-operation: any held result is discarded, counters clear, and arbitration restarts at requester 0.

Decomposition:
- Package rotation_arb_pkg holds:
  - typedef enum {EMPTY, FULL} for the output state
  - localparam NUM_REQ = 2
  - function to_right_amt(amt, dir) for the amount conversion
- Sub-module: the team's existing right_rotation module (INPUT_WIDTH=DATA_WIDTH, SHIFT_WIDTH=SHIFT_WIDTH), instantiated once on the muxed winner data and eff_amt.
- Arbiter, output register and counters live in rotation_arbiter.

Test Plan:
- After reset, req0 valid: data 8'hB4, amt 3, dir 0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'h96, rsp_id=0, grant_cnt0=1.
- req1 valid: data 8'hB4, amt 3, dir 1 -> rsp_data=8'hA5, rsp_id=1. Then left amt 0 on 8'h3C -> rsp_data=8'h3C.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 with one result per cycle; after 10 cycles grant_cnt0=5, grant_cnt1=5.
- rsp_ready=0 for 4 cycles while FULL with both requesters valid -> req_ready=2'b00, rsp_data stable. When rsp_ready rises, drain and refill occur in the same cycle and no result is lost or duplicated.
- reset_n pulsed low while FULL -> rsp_valid=0 immediately (async), counters 0, and the first post-reset grant goes to requester 0.
- CNT_WIDTH=2, 5 transfers from req0 -> grant_cnt0 reads 1,2,3,3,3 (saturates at 3).
